// File: rtl/tennis_pkg.sv
// Shared types and constants for the two-player LED tennis game.
package tennis_pkg;

    localparam int LED_W   = 16;
    localparam int POS_W   = 4;
    localparam int SCORE_W = 4;

    localparam logic [POS_W-1:0] P1_END = 4'd15;
    localparam logic [POS_W-1:0] P2_END = 4'd0;

    typedef enum logic [2:0] {
        SERVE_P1,
        SERVE_P2,
        TO_P1,
        TO_P2,
        POINT,
        OVER
    } state_e;

    // Scores above 8 simply light the whole half-bar.
    function automatic logic [7:0] therm8(input logic [SCORE_W-1:0] s);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i] = (int'(s) > i);
        end
        return t;
    endfunction

endpackage

// File: rtl/tennis_tick_gen.sv
// Ball-step tick generator: one-cycle pulse every TICK_DIV cycles, restartable via clear_i.
module tennis_tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // With TICK_DIV = 1 the counter sits at zero and tick stays high.
    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tennis_top.sv
// Two-player LED tennis on a 16-LED bar. Optional macro SCORE_DISPLAY_EN shows
// both scores as thermometer codes during POINT instead of a full-bar flash.
module tennis_top
    import tennis_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned HIT_WIN    = 2,
    parameter int unsigned SHOW_TICKS = 4,
    parameter int unsigned WIN_SCORE  = 7
) (
    input  logic             clk,
    input  logic             reset_clk,
    input  logic             but_1,
    input  logic             but_2,
    output logic [LED_W-1:0] led
);

    localparam int unsigned SHOW_W = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
    localparam logic [SHOW_W-1:0]  SHOW_LAST = SHOW_W'(SHOW_TICKS - 1);
    localparam logic [POS_W-1:0]   HIT_LO    = POS_W'(HIT_WIN);
    localparam logic [POS_W-1:0]   HIT_HI    = P1_END - HIT_LO;
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [SHOW_W-1:0]  showCnt_q, showCnt_d;
    logic               p1Scored_q, p1Scored_d;
    logic               btn1_q, btn2_q;
    logic               press1, press2;
    logic               tick;

    assign press1 = but_1 & ~btn1_q;
    assign press2 = but_2 & ~btn2_q;

    tennis_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_i   (clk),
        .reset_i (reset_clk),
        .clear_i (state_d != state_q),
        .tick_o  (tick)
    );

    // A return (hit) is checked before the tick so a hit never also moves or misses.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        showCnt_d  = showCnt_q;
        p1Scored_d = p1Scored_q;
        unique case (state_q)
            SERVE_P1: begin
                if (press1) state_d = TO_P2;
            end
            SERVE_P2: begin
                if (press2) state_d = TO_P1;
            end
            TO_P2: begin
                if (press2 && (pos_q < HIT_LO)) begin
                    state_d = TO_P1;
                end else if (tick) begin
                    if (pos_q == P2_END) begin
                        if (score1_q < WIN) score1_d = score1_q + SCORE_W'(1);
                        p1Scored_d = 1'b1;
                        showCnt_d  = '0;
                        state_d    = POINT;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                end
            end
            TO_P1: begin
                if (press1 && (pos_q > HIT_HI)) begin
                    state_d = TO_P2;
                end else if (tick) begin
                    if (pos_q == P1_END) begin
                        if (score2_q < WIN) score2_d = score2_q + SCORE_W'(1);
                        p1Scored_d = 1'b0;
                        showCnt_d  = '0;
                        state_d    = POINT;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    if (showCnt_q == SHOW_LAST) begin
                        if ((score1_q == WIN) || (score2_q == WIN)) begin
                            state_d = OVER;
                        end else if (p1Scored_q) begin
                            state_d = SERVE_P2;
                            pos_d   = P2_END;
                        end else begin
                            state_d = SERVE_P1;
                            pos_d   = P1_END;
                        end
                    end else begin
                        showCnt_d = showCnt_q + SHOW_W'(1);
                    end
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = SERVE_P1;
                pos_d   = P1_END;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            state_q    <= SERVE_P1;
            pos_q      <= P1_END;
            score1_q   <= '0;
            score2_q   <= '0;
            showCnt_q  <= '0;
            p1Scored_q <= 1'b0;
            btn1_q     <= 1'b0;
            btn2_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            showCnt_q  <= showCnt_d;
            p1Scored_q <= p1Scored_d;
            btn1_q     <= but_1;
            btn2_q     <= but_2;
        end
    end

    always_comb begin
        led = LED_W'(1) << pos_q;
        unique case (state_q)
            POINT: begin
`ifdef SCORE_DISPLAY_EN
                led = {therm8(score1_q), therm8(score2_q)};
`else
                led = 16'hFFFF;
`endif
            end
            OVER: begin
                led = (score1_q == WIN) ? 16'hFF00 : 16'h00FF;
            end
            default: begin
                led = LED_W'(1) << pos_q;
            end
        endcase
    end

endmodule

// File: tb/tb_tennis_top.sv
// Directed bench for tennis_top: a ball/direction game model checked every cycle,
// plus hand-computed LED checkpoints along a scripted match.
module tb_tennis_top;

    localparam int HIT_WIN    = 2;
    localparam int SHOW_TICKS = 4;
    localparam int WIN_SCORE  = 7;

    localparam int M_SERVE = 0;
    localparam int M_MOVE  = 1;
    localparam int M_SHOW  = 2;
    localparam int M_OVER  = 3;

    logic        clk;
    logic        reset_clk;
    logic        but_1;
    logic        but_2;
    logic [15:0] led;

    int total = 0;
    int bad   = 0;

    tennis_top #(
        .TICK_DIV   (1),
        .HIT_WIN    (HIT_WIN),
        .SHOW_TICKS (SHOW_TICKS),
        .WIN_SCORE  (WIN_SCORE)
    ) dut (
        .clk       (clk),
        .reset_clk (reset_clk),
        .but_1     (but_1),
        .but_2     (but_2),
        .led       (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          mMode, ballPos, ballDir, server, holdLeft, sc1, sc2, lastScorer;
    bit          prev1, prev2, p1, p2;
    bit          modelValid = 1'b0;
    logic [15:0] expLed;

    function automatic logic [7:0] thermOf(input int s);
        int n;
        n = (s > 8) ? 8 : s;
        return 8'(((1 << n) - 1) & 8'hFF);
    endfunction

    function automatic logic [15:0] modelLed();
        case (mMode)
            M_SHOW: begin
`ifdef SCORE_DISPLAY_EN
                return {thermOf(sc1), thermOf(sc2)};
`else
                return 16'hFFFF;
`endif
            end
            M_OVER:  return (sc1 >= WIN_SCORE) ? 16'hFF00 : 16'h00FF;
            default: return 16'(32'h1 << ballPos);
        endcase
    endfunction

    // Game model: ball position plus travel direction; a step past either end is a miss.
    always @(posedge clk) begin
        if (reset_clk) begin
            mMode = M_SERVE; server = 1; ballPos = 15; ballDir = 0;
            sc1 = 0; sc2 = 0; holdLeft = 0; lastScorer = 0;
            prev1 = 1'b0; prev2 = 1'b0; modelValid = 1'b1;
        end else if (modelValid) begin
            p1 = but_1 && !prev1;
            p2 = but_2 && !prev2;
            case (mMode)
                M_SERVE: begin
                    if (server == 1 && p1) begin mMode = M_MOVE; ballDir = -1; end
                    else if (server == 2 && p2) begin mMode = M_MOVE; ballDir = 1; end
                end
                M_MOVE: begin
                    if (ballDir < 0 && p2 && ballPos < HIT_WIN) ballDir = 1;
                    else if (ballDir > 0 && p1 && ballPos > 15 - HIT_WIN) ballDir = -1;
                    else if (ballPos + ballDir < 0 || ballPos + ballDir > 15) begin
                        lastScorer = (ballDir < 0) ? 1 : 2;
                        if (lastScorer == 1 && sc1 < WIN_SCORE) sc1++;
                        if (lastScorer == 2 && sc2 < WIN_SCORE) sc2++;
                        mMode = M_SHOW;
                        holdLeft = SHOW_TICKS;
                    end else begin
                        ballPos = ballPos + ballDir;
                    end
                end
                M_SHOW: begin
                    holdLeft--;
                    if (holdLeft == 0) begin
                        if (sc1 == WIN_SCORE || sc2 == WIN_SCORE) mMode = M_OVER;
                        else begin
                            server  = (lastScorer == 1) ? 2 : 1;
                            ballPos = (server == 1) ? 15 : 0;
                            mMode   = M_SERVE;
                        end
                    end
                end
                default: mMode = M_OVER;
            endcase
            prev1 = but_1;
            prev2 = but_2;
        end
        expLed = modelLed();
    end

    task automatic checkOutput(input string name, input logic [15:0] want);
        total++;
        if (led !== want) begin
            bad++;
            $display("[TB] FAIL %s: led=%h expected=%h at t=%0t", name, led, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) checkOutput("model", expLed);
    end

    task automatic applyStimulus(input logic b1, input logic b2, input int n);
        but_1 = b1;
        but_2 = b2;
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] pointA, pointB, pointD, pointF;

    initial begin
`ifdef SCORE_DISPLAY_EN
        pointA = 16'h0100; pointB = 16'h0101; pointD = 16'h0301; pointF = 16'h7F00;
`else
        pointA = 16'hFFFF; pointB = 16'hFFFF; pointD = 16'hFFFF; pointF = 16'hFFFF;
`endif
        reset_clk = 1'b1;
        but_1 = 1'b0;
        but_2 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetLed", 16'h8000);
        reset_clk = 1'b0;

        // Held but_1 serves once; ball reaches P2 end, P1 scores, P2 serves.
        applyStimulus(1, 0, 2);  checkOutput("firstStep", 16'h4000);
        applyStimulus(1, 0, 14); checkOutput("reachP2End", 16'h0001);
        applyStimulus(1, 0, 1);  checkOutput("pointA", pointA);
        applyStimulus(1, 0, 3);  checkOutput("pointAHeld", pointA);
        applyStimulus(1, 0, 1);  checkOutput("serveP2", 16'h0001);
        applyStimulus(1, 0, 3);
        applyStimulus(0, 0, 2);

        // P2 serves, P1 misses: P2 scores, P1 serves.
        applyStimulus(0, 1, 1);  checkOutput("p2Served", 16'h0001);
        applyStimulus(0, 0, 16); checkOutput("pointB", pointB);
        applyStimulus(0, 0, 4);  checkOutput("serveP1", 16'h8000);

        // Short but_2 pulse at pos 1 returns the ball.
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 13); checkOutput("nearP2", 16'h0004);
        applyStimulus(0, 0, 1);  checkOutput("beforeHit", 16'h0002);
        #3 but_2 = 1'b1;
        #4 but_2 = 1'b0;
        @(negedge clk);          checkOutput("hitHold", 16'h0002);
        applyStimulus(0, 0, 1);  checkOutput("reversed", 16'h0004);
        applyStimulus(0, 0, 13); checkOutput("p1End", 16'h8000);
        applyStimulus(1, 0, 1);  checkOutput("p1Return", 16'h8000);

        // but_2 outside the hit window is ignored; P1 scores.
        applyStimulus(0, 0, 11); checkOutput("earlyPress", 16'h0010);
        applyStimulus(0, 1, 1);  checkOutput("ignored", 16'h0008);
        applyStimulus(0, 0, 4);  checkOutput("pointD", pointD);
        applyStimulus(0, 0, 4);  checkOutput("serveP2b", 16'h0001);

        // Reset mid-rally.
        applyStimulus(0, 1, 1);
        applyStimulus(0, 0, 8);  checkOutput("preReset", 16'h0100);
        reset_clk = 1'b1;
        @(negedge clk);          checkOutput("afterReset", 16'h8000);
        reset_clk = 1'b0;

        // Seven straight P2 misses end the game for P1.
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 20); checkOutput("rally1Serve", 16'h0001);
        for (int r = 2; r <= 7; r++) begin
            applyStimulus(0, 1, 1);
            applyStimulus(0, 0, 15);
            applyStimulus(1, 0, 1);
            applyStimulus(0, 0, 16);
            if (r == 7) checkOutput("pointF", pointF);
            applyStimulus(0, 0, 4);
        end
        checkOutput("overLed", 16'hFF00);
        applyStimulus(1, 1, 3);
        applyStimulus(0, 0, 2);
        applyStimulus(0, 1, 2);
        checkOutput("overHold", 16'hFF00);
        applyStimulus(0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
